mem_port_model: RTL

Parametrised, synthesizable model of a DDR-controller user port: command FIFO, write-data FIFO, read-data FIFO and a backing word array with programmable read latency. It sits opposite the Raptor64 cache-fill interface (`cmd_*` / `rd_*` / `wr_*`) in simulation benches and FPGA bring-up builds. It replaces hand-coded address-decode ROM stubs, and adds:
- bursts of any length
- write support with byte masks
- multiple queued commands
- error reporting

---
 rtl/mem_port_model.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_model.sv
// Behavioural DDR user-port model: command / write / read FIFOs in front of a
// word array, with a small engine that executes queued commands in order.
module mem_port_model #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 30,
  parameter int unsigned MEM_LOG2  = 10,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned DAT_DEPTH = 64,
  parameter int unsigned RD_LAT    = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_en,
  input  logic [2:0]        cmd_instr,
  input  logic [5:0]        cmd_bl,
  input  logic [AW-1:0]     cmd_byte_addr,
  output logic              cmd_full,
  output logic              cmd_empty,
  input  logic              wr_en,
  input  logic [DW/8-1:0]   wr_mask,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_full,
  output logic [6:0]        wr_count,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              rd_empty,
  output logic [6:0]        rd_count,
  output logic              err_o
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned BSH = $clog2(NB);
  localparam int unsigned MD  = 2 ** MEM_LOG2;
  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned CCW = CAW + 1;
  localparam int unsigned DAW = $clog2(DAT_DEPTH);
  localparam int unsigned DCW = DAW + 1;
  localparam int unsigned LCW = $clog2(RD_LAT + 1);

  typedef struct packed {
    logic [2:0]          instr;
    logic [5:0]          bl;
    logic [MEM_LOG2-1:0] waddr;
  } cmd_t;

  typedef struct packed {
    logic [NB-1:0] mask;
    logic [DW-1:0] data;
  } wr_t;

  typedef enum logic [2:0] {S_IDLE, S_LAT, S_READ, S_WWAIT, S_WRITE} state_e;

  // Backing array (not reset)
  logic [DW-1:0] mem_q [MD];

  // Command FIFO
  cmd_t           cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp_q, cmd_rp_q;
  logic [CCW-1:0] cmd_cnt_q;
  logic           cmd_push, cmd_pop;
  cmd_t           cmd_in, cmd_head;

  // Write-data FIFO
  wr_t            wr_mem_q [DAT_DEPTH];
  logic [DAW-1:0] wr_wp_q, wr_rp_q;
  logic [DCW-1:0] wr_cnt_q;
  logic           wr_push, wr_pop;
  wr_t            wr_head;

  // Read-data FIFO
  logic [DW-1:0]  rd_mem_q [DAT_DEPTH];
  logic [DAW-1:0] rd_wp_q, rd_rp_q;
  logic [DCW-1:0] rd_cnt_q;
  logic           rd_push, rd_pop;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic [DW-1:0]  mem_rdata;

  // Engine
  state_e              state_q, state_d;
  logic [MEM_LOG2-1:0] addr_q, addr_d;
  logic [5:0]          bl_q, bl_d;
  logic [LCW-1:0]      lat_q, lat_d;
  logic                ill_cmd;
  logic                err_q, err_d;

  // Address bits outside the word index are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_byte_addr;

  assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
  assign cmd_empty = (cmd_cnt_q == '0);
  assign wr_full   = (wr_cnt_q == DCW'(DAT_DEPTH));
  assign wr_count  = 7'(wr_cnt_q);
  assign rd_empty  = (rd_cnt_q == '0);
  assign rd_count  = 7'(rd_cnt_q);
  assign rd_data   = rd_data_q;
  assign err_o     = err_q;

  assign cmd_in   = '{instr: cmd_instr, bl: cmd_bl,
                      waddr: MEM_LOG2'(cmd_byte_addr >> BSH)};
  assign cmd_head = cmd_mem_q[cmd_rp_q];
  assign wr_head  = wr_mem_q[wr_rp_q];
  assign mem_rdata = mem_q[addr_q];

  // A push into a full FIFO is accepted when the same cycle pops
  assign cmd_push = cmd_en && (!cmd_full || cmd_pop);
  assign wr_push  = wr_en && (!wr_full || wr_pop);
  assign rd_pop   = rd_en && !rd_empty;

  assign err_d = (cmd_en && cmd_full && !cmd_pop) ||
                 (wr_en && wr_full && !wr_pop) ||
                 (rd_en && rd_empty) ||
                 ill_cmd;

  // FIFO storage arrays and backing-array writes
  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem_q[cmd_wp_q] <= cmd_in;
    if (wr_push)  wr_mem_q[wr_wp_q]   <= '{mask: wr_mask, data: wr_data};
    if (rd_push)  rd_mem_q[rd_wp_q]   <= mem_rdata;
    if (wr_pop) begin
      for (int b = 0; b < NB; b++) begin
        if (!wr_head.mask[b]) mem_q[addr_q][b*8 +: 8] <= wr_head.data[b*8 +: 8];
      end
    end
  end

  // Next read-FIFO head: the incoming word when the FIFO would otherwise drain
  always_comb begin
    rd_data_d = rd_data_q;
    if ((rd_cnt_q - DCW'(rd_pop)) == '0) begin
      if (rd_push) rd_data_d = mem_rdata;
    end else begin
      rd_data_d = rd_mem_q[rd_rp_q + DAW'(rd_pop)];
    end
  end

  // FIFO pointers, counts, registered read head and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
      wr_wp_q   <= '0;
      wr_rp_q   <= '0;
      wr_cnt_q  <= '0;
      rd_wp_q   <= '0;
      rd_rp_q   <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + CAW'(1);
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CAW'(1);
      cmd_cnt_q <= cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
      if (wr_push)  wr_wp_q <= wr_wp_q + DAW'(1);
      if (wr_pop)   wr_rp_q <= wr_rp_q + DAW'(1);
      wr_cnt_q  <= wr_cnt_q + DCW'(wr_push) - DCW'(wr_pop);
      if (rd_push)  rd_wp_q <= rd_wp_q + DAW'(1);
      if (rd_pop)   rd_rp_q <= rd_rp_q + DAW'(1);
      rd_cnt_q  <= rd_cnt_q + DCW'(rd_push) - DCW'(rd_pop);
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // Engine state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bl_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      lat_q   <= lat_d;
    end
  end

  // Engine next-state: dispatch, latency count, read and write bursts
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bl_d    = bl_q;
    lat_d   = lat_q;
    cmd_pop = 1'b0;
    wr_pop  = 1'b0;
    rd_push = 1'b0;
    ill_cmd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_head.waddr;
          bl_d    = cmd_head.bl;
          lat_d   = '0;
          case (cmd_head.instr)
            3'b001, 3'b011: state_d = S_LAT;
            3'b000, 3'b010: state_d = S_WWAIT;
            default:        ill_cmd = 1'b1;
          endcase
        end
      end
      S_LAT: begin
        if (lat_q == LCW'(RD_LAT - 1)) state_d = S_READ;
        else                           lat_d   = lat_q + LCW'(1);
      end
      S_READ: begin
        if (!(rd_cnt_q == DCW'(DAT_DEPTH))) begin
          rd_push = 1'b1;
          addr_d  = addr_q + MEM_LOG2'(1);
          if (bl_q == '0) state_d = S_IDLE;
          else            bl_d    = bl_q - 6'd1;
        end
      end
      S_WWAIT: begin
        if (32'(wr_cnt_q) >= 32'(bl_q) + 32'd1) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_pop = 1'b1;
        addr_d = addr_q + MEM_LOG2'(1);
        if (bl_q == '0) state_d = S_IDLE;
        else            bl_d    = bl_q - 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
